// File: rtl/ov7670_pixel_capture_if.sv
// Camera parallel bus, capture enable and frame-buffer write port of the OV7670 capture block.
interface ov7670_pixel_capture_if #(
  parameter int ADDR_W = 17
);
  logic              enable;
  logic              cam_pclk;
  logic              cam_vsync;
  logic              cam_href;
  logic [7:0]        cam_data;
  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [15:0]       wdata;
  logic              frame_done;
  logic [7:0]        frame_cnt;
  logic              busy;
  logic              line_err;

  // master: camera/configuration side; slave: the capture block
  modport master (
    output enable, cam_pclk, cam_vsync, cam_href, cam_data,
    input  we, waddr, wdata, frame_done, frame_cnt, busy, line_err
  );
  modport slave (
    input  enable, cam_pclk, cam_vsync, cam_href, cam_data,
    output we, waddr, wdata, frame_done, frame_cnt, busy, line_err
  );
endinterface

// File: rtl/ov7670_pixel_capture.sv
// Oversamples the OV7670 parallel bus in the system clock domain, pairs bytes into RGB565
// pixels and issues frame-buffer writes with linear addresses (optional 2:1 decimation).
module ov7670_pixel_capture #(
  parameter int H_PIX     = 640,
  parameter int V_PIX     = 480,
  parameter int DOWNSCALE = 1,
  parameter int ADDR_W    = 17
) (
  input  logic                  clk,
  input  logic                  reset,
  ov7670_pixel_capture_if.slave bus
);
  localparam int H_OUT = H_PIX >> DOWNSCALE;
  localparam int X_W   = $clog2(H_PIX + 1);
  localparam int Y_W   = $clog2(V_PIX + 1);
  localparam int B_W   = $clog2(2 * H_PIX + 2);
  localparam logic [X_W-1:0] X_MAX  = X_W'(H_PIX);
  localparam logic [Y_W-1:0] Y_MAX  = Y_W'(V_PIX);
  localparam logic [B_W-1:0] B_LINE = B_W'(2 * H_PIX);
  localparam logic [B_W-1:0] B_MAX  = B_W'(2 * H_PIX + 1);

  localparam logic [1:0] S_WAIT_CFG   = 2'd0;
  localparam logic [1:0] S_WAIT_FRAME = 2'd1;
  localparam logic [1:0] S_CAPTURE    = 2'd2;

  logic [2:0]      pclk_sync_q, pclk_sync_d;
  logic [2:0]      vsync_sync_q, vsync_sync_d;
  logic [2:0]      href_sync_q, href_sync_d;
  logic [2:0][7:0] data_sync_q, data_sync_d;
  logic            pclk_rise_q, pclk_rise_d;
  logic            vsync_rise_q, vsync_rise_d;
  logic            vsync_fall_q, vsync_fall_d;
  logic            href_fall_q, href_fall_d;

  logic [1:0]        state_q, state_d;
  logic [X_W-1:0]    x_q, x_d;
  logic [Y_W-1:0]    y_q, y_d;
  logic [B_W-1:0]    bcnt_q, bcnt_d;
  logic              phase_q, phase_d;
  logic [7:0]        hi_q, hi_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [15:0]       wdata_q, wdata_d;
  logic              frame_done_q, frame_done_d;
  logic [7:0]        frame_cnt_q, frame_cnt_d;
  logic              busy_q, busy_d;
  logic              line_err_q, line_err_d;

  logic       vsync_lvl, href_lvl;
  logic [7:0] byte_lvl;
  logic       in_range, keep_px;

  // Stage 2 of each chain is the current sample, stage 3 the previous one; the edge strobes
  // are registered, so stage 3 levels line up with them.
  always_comb begin
    pclk_sync_d  = {pclk_sync_q[1:0], bus.cam_pclk};
    vsync_sync_d = {vsync_sync_q[1:0], bus.cam_vsync};
    href_sync_d  = {href_sync_q[1:0], bus.cam_href};
    data_sync_d  = {data_sync_q[1:0], bus.cam_data};
    pclk_rise_d  = pclk_sync_q[1] & ~pclk_sync_q[2];
    vsync_rise_d = vsync_sync_q[1] & ~vsync_sync_q[2];
    vsync_fall_d = ~vsync_sync_q[1] & vsync_sync_q[2];
    href_fall_d  = ~href_sync_q[1] & href_sync_q[2];
  end

  assign vsync_lvl = vsync_sync_q[2];
  assign href_lvl  = href_sync_q[2];
  assign byte_lvl  = data_sync_q[2];

  always_comb begin
    state_d      = state_q;
    x_d          = x_q;
    y_d          = y_q;
    bcnt_d       = bcnt_q;
    phase_d      = phase_q;
    hi_d         = hi_q;
    we_d         = 1'b0;
    waddr_d      = waddr_q;
    wdata_d      = wdata_q;
    frame_done_d = 1'b0;
    frame_cnt_d  = frame_cnt_q;
    line_err_d   = line_err_q;
    in_range     = (x_q < X_MAX) && (y_q < Y_MAX);
    keep_px      = (DOWNSCALE == 0) || (!x_q[0] && !y_q[0]);

    if (!bus.enable) begin
      state_d = S_WAIT_CFG;
    end else begin
      case (state_q)
        S_WAIT_CFG: state_d = S_WAIT_FRAME;
        S_WAIT_FRAME: begin
          if (vsync_fall_q) begin
            state_d = S_CAPTURE;
            x_d     = '0;
            y_d     = '0;
            bcnt_d  = '0;
            phase_d = 1'b0;
          end
        end
        S_CAPTURE: begin
          if (vsync_rise_q) begin
            state_d      = S_WAIT_FRAME;
            frame_done_d = 1'b1;
            frame_cnt_d  = frame_cnt_q + 8'd1;
          end else if (href_fall_q && !vsync_lvl) begin
            if (x_q != '0 && y_q != Y_MAX) y_d = y_q + Y_W'(1);
            if (bcnt_q != B_LINE) line_err_d = 1'b1;
            x_d     = '0;
            bcnt_d  = '0;
            phase_d = 1'b0;
          end else if (pclk_rise_q && href_lvl && !vsync_lvl) begin
            if (bcnt_q != B_MAX) bcnt_d = bcnt_q + B_W'(1);
            if (!phase_q) begin
              hi_d    = byte_lvl;
              phase_d = 1'b1;
            end else begin
              phase_d = 1'b0;
              if (!in_range) begin
                line_err_d = 1'b1;
              end else if (keep_px) begin
                we_d    = 1'b1;
                wdata_d = {hi_q, byte_lvl};
                waddr_d = ADDR_W'(y_q >> DOWNSCALE) * ADDR_W'(H_OUT) + ADDR_W'(x_q >> DOWNSCALE);
              end
              if (x_q != X_MAX) x_d = x_q + X_W'(1);
            end
          end
        end
        default: state_d = S_WAIT_CFG;
      endcase
    end
    busy_d = (state_d == S_CAPTURE);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      pclk_sync_q  <= '0;
      vsync_sync_q <= '0;
      href_sync_q  <= '0;
      data_sync_q  <= '0;
      pclk_rise_q  <= 1'b0;
      vsync_rise_q <= 1'b0;
      vsync_fall_q <= 1'b0;
      href_fall_q  <= 1'b0;
      state_q      <= S_WAIT_CFG;
      x_q          <= '0;
      y_q          <= '0;
      bcnt_q       <= '0;
      phase_q      <= 1'b0;
      hi_q         <= '0;
      we_q         <= 1'b0;
      waddr_q      <= '0;
      wdata_q      <= '0;
      frame_done_q <= 1'b0;
      frame_cnt_q  <= '0;
      busy_q       <= 1'b0;
      line_err_q   <= 1'b0;
    end else begin
      pclk_sync_q  <= pclk_sync_d;
      vsync_sync_q <= vsync_sync_d;
      href_sync_q  <= href_sync_d;
      data_sync_q  <= data_sync_d;
      pclk_rise_q  <= pclk_rise_d;
      vsync_rise_q <= vsync_rise_d;
      vsync_fall_q <= vsync_fall_d;
      href_fall_q  <= href_fall_d;
      state_q      <= state_d;
      x_q          <= x_d;
      y_q          <= y_d;
      bcnt_q       <= bcnt_d;
      phase_q      <= phase_d;
      hi_q         <= hi_d;
      we_q         <= we_d;
      waddr_q      <= waddr_d;
      wdata_q      <= wdata_d;
      frame_done_q <= frame_done_d;
      frame_cnt_q  <= frame_cnt_d;
      busy_q       <= busy_d;
      line_err_q   <= line_err_d;
    end
  end

  assign bus.we         = we_q;
  assign bus.waddr      = waddr_q;
  assign bus.wdata      = wdata_q;
  assign bus.frame_done = frame_done_q;
  assign bus.frame_cnt  = frame_cnt_q;
  assign bus.busy       = busy_q;
  assign bus.line_err   = line_err_q;
endmodule
